// File: rtl/usb_protocol_ctrl.sv
// usb_protocol_ctrl: USB bulk-endpoint protocol controller.
// Decodes host tokens/handshakes from USB RX, picks DATA/ACK/NAK
// responses for USB TX and drives buffer status and clear.
// Ports: clk, n_rst (async low); rx_packet_valid, rx_packet[2:0],
// rx_error, tx_done, buffer_occupancy[6:0], buffer_reserved,
// tx_packet_data_size[6:0] in; tx_start, tx_packet[1:0],
// rx/tx_transfer_active, rx_data_ready, rx/tx_error_flag, clear out.
// Optional macro PC_TIMEOUT_EN adds a host-response timeout
// (TIMEOUT_CYC cycles) in RX_DATA and TX_WAIT.
module usb_protocol_ctrl #(
  parameter int BUF_DEPTH = 64
`ifdef PC_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_packet_valid,
  input  logic [2:0] rx_packet,
  input  logic       rx_error,
  input  logic       tx_done,
  input  logic [6:0] buffer_occupancy,
  input  logic       buffer_reserved,
  input  logic [6:0] tx_packet_data_size,
  output logic       tx_start,
  output logic [1:0] tx_packet,
  output logic       rx_transfer_active,
  output logic       tx_transfer_active,
  output logic       rx_data_ready,
  output logic       rx_error_flag,
  output logic       tx_error_flag,
  output logic       clear
);

  typedef enum logic [2:0] {
    IDLE, RX_DATA, RX_ACK, RX_NAK,
    TX_DATA, TX_WAIT, TX_NAK
  } state_t;

  localparam logic [2:0] PID_OUT  = 3'd1;
  localparam logic [2:0] PID_IN   = 3'd2;
  localparam logic [2:0] PID_DATA = 3'd3;
  localparam logic [2:0] PID_ACK  = 3'd4;

  localparam logic [1:0] TXP_NONE = 2'd0;
  localparam logic [1:0] TXP_DATA = 2'd1;
  localparam logic [1:0] TXP_ACK  = 2'd2;
  localparam logic [1:0] TXP_NAK  = 2'd3;

  localparam logic [6:0] DEPTH = 7'(BUF_DEPTH);

  state_t     state_q, state_d;
  logic       tx_start_q, tx_start_d;
  logic [1:0] tx_packet_q, tx_packet_d;
  logic       rx_act_q, rx_act_d;
  logic       tx_act_q, tx_act_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       rx_err_q, rx_err_d;
  logic       tx_err_q, tx_err_d;
  logic       clear_q, clear_d;

`ifdef PC_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYC - 1);
  logic [9:0] timer_q, timer_d;
  logic       timeout;
  assign timeout = (timer_q == TO_LAST);
`endif

  // rx_error masks any packet decoded in the same cycle
  logic pkt_ok, out_tok, in_tok, data_pkt, ack_pkt;
  logic in_ready;
  assign pkt_ok   = rx_packet_valid && !rx_error;
  assign out_tok  = pkt_ok && (rx_packet == PID_OUT);
  assign in_tok   = pkt_ok && (rx_packet == PID_IN);
  assign data_pkt = pkt_ok && (rx_packet == PID_DATA);
  assign ack_pkt  = pkt_ok && (rx_packet == PID_ACK);

  assign in_ready = (tx_packet_data_size != 7'd0) &&
                    (tx_packet_data_size <= DEPTH) &&
                    (buffer_occupancy >= tx_packet_data_size);

  always_comb begin
    state_d  = state_q;
    rx_err_d = rx_err_q;
    tx_err_d = tx_err_q;
    clear_d  = 1'b0;
    rx_rdy_d = rx_rdy_q && (buffer_occupancy != 7'd0);
    unique case (state_q)
      IDLE: begin
        if (out_tok) begin
          if (buffer_occupancy == 7'd0 && !buffer_reserved) begin
            state_d  = RX_DATA;
            rx_err_d = 1'b0;
          end else begin
            state_d = RX_NAK;
          end
        end else if (in_tok) begin
          if (in_ready) begin
            state_d  = TX_DATA;
            tx_err_d = 1'b0;
          end else begin
            state_d = TX_NAK;
          end
        end
      end
      RX_DATA: begin
        if (data_pkt) begin
          state_d = RX_ACK;
        end else if (rx_error || rx_packet_valid) begin
          state_d  = RX_NAK;
          rx_err_d = 1'b1;
          clear_d  = 1'b1;
`ifdef PC_TIMEOUT_EN
        end else if (timeout) begin
          state_d  = IDLE;
          rx_err_d = 1'b1;
          clear_d  = 1'b1;
`endif
        end
      end
      RX_ACK: begin
        if (tx_done) begin
          state_d  = IDLE;
          rx_rdy_d = 1'b1;
        end
      end
      RX_NAK, TX_NAK: begin
        if (tx_done) state_d = IDLE;
      end
      TX_DATA: begin
        if (tx_done) state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (ack_pkt) begin
          state_d = IDLE;
        end else if (rx_error || rx_packet_valid) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
          clear_d  = 1'b1;
`ifdef PC_TIMEOUT_EN
        end else if (timeout) begin
          state_d  = IDLE;
          tx_err_d = 1'b1;
          clear_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_d) rx_rdy_d = 1'b0;
  end

  // Moore outputs are computed from the next state and registered
  always_comb begin
    tx_packet_d = TXP_NONE;
    unique case (state_d)
      RX_ACK:          tx_packet_d = TXP_ACK;
      RX_NAK, TX_NAK:  tx_packet_d = TXP_NAK;
      TX_DATA:         tx_packet_d = TXP_DATA;
      default:         tx_packet_d = TXP_NONE;
    endcase
    tx_start_d = (state_d != state_q) && (tx_packet_d != TXP_NONE);
    rx_act_d   = (state_d == RX_DATA) || (state_d == RX_ACK);
    tx_act_d   = (state_d == TX_DATA) || (state_d == TX_WAIT);
  end

`ifdef PC_TIMEOUT_EN
  always_comb begin
    timer_d = 10'd0;
    if (state_d == state_q &&
        (state_q == RX_DATA || state_q == TX_WAIT))
      timer_d = timer_q + 10'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) timer_q <= 10'd0;
    else        timer_q <= timer_d;
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      tx_start_q  <= 1'b0;
      tx_packet_q <= TXP_NONE;
      rx_act_q    <= 1'b0;
      tx_act_q    <= 1'b0;
      rx_rdy_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      tx_err_q    <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_start_q  <= tx_start_d;
      tx_packet_q <= tx_packet_d;
      rx_act_q    <= rx_act_d;
      tx_act_q    <= tx_act_d;
      rx_rdy_q    <= rx_rdy_d;
      rx_err_q    <= rx_err_d;
      tx_err_q    <= tx_err_d;
      clear_q     <= clear_d;
    end
  end

  assign tx_start           = tx_start_q;
  assign tx_packet          = tx_packet_q;
  assign rx_transfer_active = rx_act_q;
  assign tx_transfer_active = tx_act_q;
  assign rx_data_ready      = rx_rdy_q;
  assign rx_error_flag      = rx_err_q;
  assign tx_error_flag      = tx_err_q;
  assign clear              = clear_q;

endmodule
